msf_store_sequencer: RTL and testbench
======================================

Name: msf_store_sequencer

Overview:
- Sequences the read-modify-write of the MSF per-second and per-minute level accumulator memories around the `data_flow` datapath.
- For each accepted level sample it does four things:
  - Computes the second-bin and minute-bin addresses.
  - Reads both stored levels.
  - Waits for the `data_flow` result.
  - Writes the result back.
- Also tracks bin/second position from the timing marks, sweeps the memories to zero on request, and flags dropped samples.
- Sits between the MSF level source, the two accumulator BRAMs and `data_flow`.

Parameters:
- SAMPLES_PER_BIN, 10, accepted samples per second-bin.
- SEC_BINS, 100, bins per second; second memory depth.
- MIN_BINS, 60, bins per minute (one per second); minute memory depth.
- SEC_AW, 7, second memory address width.
- MIN_AW, 6, minute memory address width.
- RD_LAT, 1, BRAM read latency in cycles (>=1).
- DF_LAT, 1, `data_flow` latency in cycles (>=0).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; new MSF level available.
- sample_level  in  16  MSF level accompanying sample_valid.
- sec_mark  in  1  one-cycle pulse at start of each second.
- min_mark  in  1  one-cycle pulse at start of each minute.
- clear_req  in  1  one-cycle request to zero both memories.
- df_second  in  32  level_to_store_second from `data_flow`.
- df_minute  in  32  level_to_store_minute from `data_flow`.
- df_level  out  16  held level driven to `data_flow` msf_level.
- sec_addr  out  SEC_AW  second memory address.
- min_addr  out  MIN_AW  minute memory address.
- mem_rd_en  out  1  read enable, both memories.
- sec_we  out  1  second memory write enable.
- min_we  out  1  minute memory write enable.
- sec_wdata  out  32  second memory write data.
- min_wdata  out  32  minute memory write data.
- busy  out  1  high whenever the FSM is not IDLE.
- overrun  out  1  sticky; a sample was dropped. Cleared by rst or clear completion.
- clear_done  out  1  one-cycle pulse after the sweep's last write.

Behaviour:
- **Reset:**
  - All outputs are 0 and the FSM is in IDLE.
  - Counters are zero: smp_cnt, bin_idx, sec_idx.
  - Any pending clear is dropped.
  - rst mid-RMW or mid-sweep aborts with no further writes.
- **FSM states:** IDLE, RD, WAIT, DF, WR, CLR.
- **IDLE priority:** clear_pend, then sample_valid.
- **Sample accepted in IDLE at cycle T:**
  - df_level <= sample_level.
  - sec_addr <= bin_idx and min_addr <= sec_idx; these hold until WR ends.
  - Next state is RD.
- **RD (T+1):** mem_rd_en=1 for one cycle.
- **WAIT:** RD_LAT cycles.
- **DF:** DF_LAT cycles, skipped if 0.
- **WR:**
  - sec_we = min_we = 1 for one cycle.
  - sec_wdata = df_second, min_wdata = df_minute.
  - Next state is IDLE.
- **Timing at defaults:** we asserted at T+4; next sample acceptable at T+5.
- **busy:** high from T+1 through the WR cycle.
- **Dropped samples:** sample_valid while not IDLE, or in IDLE while clear_pend is set, is dropped, sets overrun, and does not advance counters.
- **Counter update on accept:**
  - smp_cnt increments.
  - When smp_cnt was SAMPLES_PER_BIN-1: smp_cnt <= 0 and bin_idx increments, wrapping SEC_BINS-1 -> 0.
- **sec_mark:** smp_cnt <= 0, bin_idx <= 0, sec_idx <= sec_idx+1, wrapping MIN_BINS-1 -> 0.
- **min_mark:** sec_idx <= 0; overrides sec_mark's increment when simultaneous.
- **Marks and the RMW:**
  - Marks act on counters in any state; an in-flight RMW keeps its registered addresses.
  - Mark coincident with an accept: the sample uses pre-mark addresses; the mark wins the counter update.
- **Clear:**
  - clear_req sets clear_pend in any state; it is served from IDLE after any in-flight WR.
  - CLR sweeps address a = 0 .. max(SEC_BINS, MIN_BINS)-1, one address per cycle, with write data 0.
  - sec_we = (a < SEC_BINS) and min_we = (a < MIN_BINS).
  - After the last address: clear_done pulses, overrun <= 0, clear_pend <= 0, next state IDLE.
  - Counters are not altered by clear.
  - clear_req during CLR is ignored.
- **Write data:** sec_wdata/min_wdata are 0 outside WR and CLR.

Decomposition:
- Package msf_store_pkg holds:
  - state encoding enum;
  - default constants: SEC_BINS, MIN_BINS, address widths, data widths 16/32.
- One sub-module, msf_bin_counter: smp_cnt/bin_idx/sec_idx with mark handling; outputs bin_idx and sec_idx.
- FSM and memory sequencing stay in the top module.

Test Plan:
- Reset, then sample_valid with level 0x0008, df_second=0x00000109 -> mem_rd_en at T+1 with sec_addr=0, min_addr=0; sec_we at T+4 with sec_wdata=0x00000109; busy T+1..T+4.
- SAMPLES_PER_BIN=2: 5 spaced samples -> sec_addr sequence 0,0,1,1,2; sec_mark then a sample -> sec_addr=0, min_addr=1.
- Second sample_valid at T+2 -> dropped, overrun=1, that sample issues no RD; next spaced sample still uses the correct bin.
- sec_mark and min_mark in the same cycle with sec_idx=59 -> sec_idx=0. Mark coincident with accept -> that RMW uses old addresses; next sample uses bin 0.
- clear_req during WR -> WR completes, then 100 consecutive writes of 0: sec_we for addresses 0..99, min_we only for 0..59; clear_done pulses once; overrun=0.
- rst asserted mid-WAIT -> no write; outputs 0; IDLE next cycle; a pending clear is not executed.

Source files
------------

// File: rtl/msf_store_pkg.sv
// Shared constants for the MSF level-store sequencer: bus widths, default
// memory geometry and latencies, FSM state encoding and a counter-width helper.
package msf_store_pkg;

  localparam int unsigned LEVEL_W = 16;
  localparam int unsigned DATA_W  = 32;

  localparam int unsigned SAMPLES_PER_BIN_DEF = 10;
  localparam int unsigned SEC_BINS_DEF        = 100;
  localparam int unsigned MIN_BINS_DEF        = 60;
  localparam int unsigned SEC_AW_DEF          = 7;
  localparam int unsigned MIN_AW_DEF          = 6;
  localparam int unsigned RD_LAT_DEF          = 1;
  localparam int unsigned DF_LAT_DEF          = 1;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DF   = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_CLR  = 3'd5;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msf_bin_counter.sv
// Tracks the sample position inside the current second-bin (smp_cnt), the
// second-bin index (bin_idx) and the second-of-minute index (sec_idx).
// Ports: clk, rst (sync, active-high), accept (sample taken by the FSM),
// sec_mark / min_mark (timing marks), bin_idx / sec_idx (registered outputs).
module msf_bin_counter
  import msf_store_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIN = SAMPLES_PER_BIN_DEF,
  parameter int unsigned SEC_BINS        = SEC_BINS_DEF,
  parameter int unsigned MIN_BINS        = MIN_BINS_DEF,
  parameter int unsigned SEC_AW          = SEC_AW_DEF,
  parameter int unsigned MIN_AW          = MIN_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              sec_mark,
  input  logic              min_mark,
  output logic [SEC_AW-1:0] bin_idx,
  output logic [MIN_AW-1:0] sec_idx
);

  localparam int unsigned SMP_W = cnt_w(SAMPLES_PER_BIN);

  logic [SMP_W-1:0] smp_cnt;

  // A mark takes precedence over an accept for the counters it touches;
  // min_mark overrides the sec_mark increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt <= '0;
      bin_idx <= '0;
      sec_idx <= '0;
    end else begin
      if (sec_mark) begin
        smp_cnt <= '0;
        bin_idx <= '0;
      end else if (accept) begin
        if (smp_cnt == SMP_W'(SAMPLES_PER_BIN - 1)) begin
          smp_cnt <= '0;
          bin_idx <= (bin_idx == SEC_AW'(SEC_BINS - 1)) ? '0 : bin_idx + SEC_AW'(1);
        end else begin
          smp_cnt <= smp_cnt + SMP_W'(1);
        end
      end

      if (min_mark) begin
        sec_idx <= '0;
      end else if (sec_mark) begin
        sec_idx <= (sec_idx == MIN_AW'(MIN_BINS - 1)) ? '0 : sec_idx + MIN_AW'(1);
      end
    end
  end

endmodule

// File: rtl/msf_store_sequencer.sv
// Read-modify-write sequencer for the MSF per-second / per-minute level
// accumulator memories around data_flow, plus a zeroing sweep on request.
// Ports: clk, rst (sync, active-high); sample_valid/sample_level from the
// level source; sec_mark/min_mark timing marks; clear_req sweep request;
// df_second/df_minute results from data_flow; df_level held level to
// data_flow; sec_addr/min_addr, mem_rd_en, sec_we/min_we, sec_wdata/min_wdata
// memory ports; busy, overrun (sticky drop flag), clear_done pulse.
module msf_store_sequencer
  import msf_store_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIN = SAMPLES_PER_BIN_DEF,
  parameter int unsigned SEC_BINS        = SEC_BINS_DEF,
  parameter int unsigned MIN_BINS        = MIN_BINS_DEF,
  parameter int unsigned SEC_AW          = SEC_AW_DEF,
  parameter int unsigned MIN_AW          = MIN_AW_DEF,
  parameter int unsigned RD_LAT          = RD_LAT_DEF,
  parameter int unsigned DF_LAT          = DF_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [LEVEL_W-1:0] sample_level,
  input  logic               sec_mark,
  input  logic               min_mark,
  input  logic               clear_req,
  input  logic [DATA_W-1:0]  df_second,
  input  logic [DATA_W-1:0]  df_minute,
  output logic [LEVEL_W-1:0] df_level,
  output logic [SEC_AW-1:0]  sec_addr,
  output logic [MIN_AW-1:0]  min_addr,
  output logic               mem_rd_en,
  output logic               sec_we,
  output logic               min_we,
  output logic [DATA_W-1:0]  sec_wdata,
  output logic [DATA_W-1:0]  min_wdata,
  output logic               busy,
  output logic               overrun,
  output logic               clear_done
);

  localparam int unsigned CLR_DEPTH = (SEC_BINS > MIN_BINS) ? SEC_BINS : MIN_BINS;
  localparam int unsigned CLR_W     = cnt_w(CLR_DEPTH);
  localparam int unsigned LAT_W     = cnt_w(((RD_LAT > DF_LAT) ? RD_LAT : DF_LAT) + 1);

  logic [2:0]         state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [CLR_W-1:0]   clr_cnt, clr_nxt, clr_a;
  logic               clear_pend, clear_pend_nxt;
  logic               enter_wr;
  logic [LEVEL_W-1:0] df_level_nxt;
  logic [SEC_AW-1:0]  sec_addr_nxt;
  logic [MIN_AW-1:0]  min_addr_nxt;
  logic               rd_en_nxt, sec_we_nxt, min_we_nxt;
  logic [DATA_W-1:0]  sec_wdata_nxt, min_wdata_nxt;
  logic               busy_nxt, overrun_nxt, clear_done_nxt;
  logic               accept_c, drop_c;
  logic [SEC_AW-1:0]  bin_idx;
  logic [MIN_AW-1:0]  sec_idx;

  // A pending clear blocks new samples so the sweep cannot be starved.
  assign accept_c = (state == ST_IDLE) && !clear_pend && sample_valid;
  assign drop_c   = sample_valid && !accept_c;

  msf_bin_counter #(
    .SAMPLES_PER_BIN (SAMPLES_PER_BIN),
    .SEC_BINS        (SEC_BINS),
    .MIN_BINS        (MIN_BINS),
    .SEC_AW          (SEC_AW),
    .MIN_AW          (MIN_AW)
  ) u_bin_counter (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept_c),
    .sec_mark (sec_mark),
    .min_mark (min_mark),
    .bin_idx  (bin_idx),
    .sec_idx  (sec_idx)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      clr_cnt    <= '0;
      clear_pend <= 1'b0;
      df_level   <= '0;
      sec_addr   <= '0;
      min_addr   <= '0;
      mem_rd_en  <= 1'b0;
      sec_we     <= 1'b0;
      min_we     <= 1'b0;
      sec_wdata  <= '0;
      min_wdata  <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      clr_cnt    <= clr_nxt;
      clear_pend <= clear_pend_nxt;
      df_level   <= df_level_nxt;
      sec_addr   <= sec_addr_nxt;
      min_addr   <= min_addr_nxt;
      mem_rd_en  <= rd_en_nxt;
      sec_we     <= sec_we_nxt;
      min_we     <= min_we_nxt;
      sec_wdata  <= sec_wdata_nxt;
      min_wdata  <= min_wdata_nxt;
      busy       <= busy_nxt;
      overrun    <= overrun_nxt;
      clear_done <= clear_done_nxt;
    end
  end

  // Next state and next output values; outputs describe the cycle in state_nxt.
  always_comb begin
    state_nxt      = state;
    lat_nxt        = lat_cnt;
    clr_nxt        = clr_cnt;
    clr_a          = clr_cnt + CLR_W'(1);
    enter_wr       = 1'b0;
    df_level_nxt   = df_level;
    sec_addr_nxt   = sec_addr;
    min_addr_nxt   = min_addr;
    rd_en_nxt      = 1'b0;
    sec_we_nxt     = 1'b0;
    min_we_nxt     = 1'b0;
    sec_wdata_nxt  = '0;
    min_wdata_nxt  = '0;
    clear_done_nxt = 1'b0;
    clear_pend_nxt = clear_pend || (clear_req && (state != ST_CLR));
    overrun_nxt    = overrun;

    case (state)
      ST_IDLE: begin
        if (clear_pend) begin
          state_nxt    = ST_CLR;
          clr_nxt      = '0;
          sec_addr_nxt = '0;
          min_addr_nxt = '0;
          sec_we_nxt   = 1'b1;
          min_we_nxt   = 1'b1;
        end else if (sample_valid) begin
          state_nxt    = ST_RD;
          df_level_nxt = sample_level;
          sec_addr_nxt = bin_idx;
          min_addr_nxt = sec_idx;
          rd_en_nxt    = 1'b1;
        end
      end
      ST_RD: begin
        state_nxt = ST_WAIT;
        lat_nxt   = '0;
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
          if (DF_LAT == 0) begin
            enter_wr = 1'b1;
          end else begin
            state_nxt = ST_DF;
            lat_nxt   = '0;
          end
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_DF: begin
        if (lat_cnt == LAT_W'(DF_LAT - 1)) begin
          enter_wr = 1'b1;
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_WR: begin
        state_nxt = ST_IDLE;
      end
      ST_CLR: begin
        if (clr_cnt == CLR_W'(CLR_DEPTH - 1)) begin
          state_nxt      = ST_IDLE;
          clear_done_nxt = 1'b1;
          clear_pend_nxt = 1'b0;
          overrun_nxt    = 1'b0;
        end else begin
          clr_nxt      = clr_a;
          sec_addr_nxt = SEC_AW'(clr_a);
          min_addr_nxt = MIN_AW'(clr_a);
          sec_we_nxt   = 32'(clr_a) < SEC_BINS;
          min_we_nxt   = 32'(clr_a) < MIN_BINS;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // data_flow output is captured on the edge that enters WR.
    if (enter_wr) begin
      state_nxt     = ST_WR;
      sec_we_nxt    = 1'b1;
      min_we_nxt    = 1'b1;
      sec_wdata_nxt = df_second;
      min_wdata_nxt = df_minute;
    end

    if (drop_c) begin
      overrun_nxt = 1'b1;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_msf_store_sequencer.sv
// Self-checking bench for msf_store_sequencer (SAMPLES_PER_BIN = 2).
module tb_msf_store_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_level;
  logic        sec_mark;
  logic        min_mark;
  logic        clear_req;
  logic [31:0] df_second;
  logic [31:0] df_minute;
  logic [15:0] df_level;
  logic [6:0]  sec_addr;
  logic [5:0]  min_addr;
  logic        mem_rd_en;
  logic        sec_we;
  logic        min_we;
  logic [31:0] sec_wdata;
  logic [31:0] min_wdata;
  logic        busy;
  logic        overrun;
  logic        clear_done;

  always #5 clk = ~clk;

  msf_store_sequencer #(.SAMPLES_PER_BIN(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_level (sample_level),
    .sec_mark     (sec_mark),
    .min_mark     (min_mark),
    .clear_req    (clear_req),
    .df_second    (df_second),
    .df_minute    (df_minute),
    .df_level     (df_level),
    .sec_addr     (sec_addr),
    .min_addr     (min_addr),
    .mem_rd_en    (mem_rd_en),
    .sec_we       (sec_we),
    .min_we       (min_we),
    .sec_wdata    (sec_wdata),
    .min_wdata    (min_wdata),
    .busy         (busy),
    .overrun      (overrun),
    .clear_done   (clear_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [6:0]  sa;
    logic [5:0]  ma;
    logic [15:0] lvl;
    logic [31:0] ds;
    logic [31:0] dm;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic        sm;
    logic        mm;
    logic [15:0] lvl;
    logic [31:0] ds;
    logic [31:0] dm;
    logic [6:0]  sa;
    logic [5:0]  ma;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] sa, input logic [5:0] ma,
                          input logic [15:0] lvl, input logic [31:0] ds, input logic [31:0] dm);
    exp_t e;
    e.sa = sa; e.ma = ma; e.lvl = lvl; e.ds = ds; e.dm = dm;
    exp_q.push_back(e);
  endtask

  // Scoreboard: reads check addresses/level, writes pop and check data.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_rd_en) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 128'(mem_rd_en), 128'(0));
        else chk("rd_addr", 128'({sec_addr, min_addr, df_level}),
                 128'({exp_q[0].sa, exp_q[0].ma, exp_q[0].lvl}));
      end
      if (sec_we || min_we) begin
        if (exp_q.size() == 0) chk("wr_unexpected", 128'({sec_we, min_we}), 128'(0));
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_data", 128'({sec_we, min_we, sec_addr, min_addr, sec_wdata, min_wdata}),
              128'({2'b11, e.sa, e.ma, e.ds, e.dm}));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; sec_mark = 1'b0; min_mark = 1'b0; clear_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] lvl, input logic [31:0] ds, input logic [31:0] dm,
                      input logic sm, input logic mm, input logic push,
                      input logic [6:0] esa, input logic [5:0] ema);
    @(negedge clk);
    sample_valid = 1'b1; sample_level = lvl; sec_mark = sm; min_mark = mm;
    if (push) begin
      df_second = ds; df_minute = dm;
      push_exp(esa, ema, lvl, ds, dm);
    end
    @(negedge clk);
    sample_valid = 1'b0; sec_mark = 1'b0; min_mark = 1'b0;
  endtask

  task automatic pulse_marks(input logic sm, input logic mm);
    @(negedge clk);
    sec_mark = sm; min_mark = mm;
    @(negedge clk);
    sec_mark = 1'b0; min_mark = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    chk(name, 128'(busy), 128'(0));
  endtask

  logic [6:0] sa_tab [9] = '{7'd0, 7'd0, 7'd1, 7'd1, 7'd2, 7'd0, 7'd0, 7'd1, 7'd0};
  logic [5:0] ma_tab [9] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, 6'd0};
  logic       sm_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       mm_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] t1_exp [1:5] = '{4'b1100, 4'b1000, 4'b1000, 4'b1011, 4'b0000};

  initial begin
    bit found;
    logic mw;

    rst = 1'b1; sample_valid = 1'b0; sample_level = '0; sec_mark = 1'b0; min_mark = 1'b0;
    clear_req = 1'b0; df_second = '0; df_minute = '0;
    for (int i = 0; i < 9; i++) begin
      vecs[i].sm  = sm_tab[i];
      vecs[i].mm  = mm_tab[i];
      vecs[i].lvl = 16'h0100 + 16'(i);
      vecs[i].ds  = 32'h0000_A000 + 32'(i);
      vecs[i].dm  = 32'h0000_B000 + 32'(i);
      vecs[i].sa  = sa_tab[i];
      vecs[i].ma  = ma_tab[i];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", 128'({df_level, sec_addr, min_addr, mem_rd_en, sec_we, min_we,
                               sec_wdata, min_wdata, busy, overrun, clear_done}), 128'(0));
    mon_en = 1'b1;

    // Basic RMW timing: {busy, mem_rd_en, sec_we, min_we} over T+1..T+5
    @(negedge clk);
    sample_valid = 1'b1; sample_level = 16'h0008; df_second = 32'h0000_0109; df_minute = 32'h0000_020A;
    push_exp(7'd0, 6'd0, 16'h0008, 32'h0000_0109, 32'h0000_020A);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) sample_valid = 1'b0;
      chk($sformatf("t1_cycle%0d", k), 128'({busy, mem_rd_en, sec_we, min_we}), 128'(t1_exp[k]));
    end
    chk("t1_wdata_idle", 128'({sec_wdata, min_wdata}), 128'(0));

    // Table: bin sequencing with SAMPLES_PER_BIN = 2 and marks
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].sm || vecs[i].mm) pulse_marks(vecs[i].sm, vecs[i].mm);
      send(vecs[i].lvl, vecs[i].ds, vecs[i].dm, 1'b0, 1'b0, 1'b1, vecs[i].sa, vecs[i].ma);
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // Drop: second sample while busy is lost and does not advance counters
    send(16'h0A0A, 32'h0000_00A1, 32'h0000_00A2, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    send(16'h0B0B, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    chk("overrun_set", 128'(overrun), 128'(1));
    wait_idle("drop_idle");
    send(16'h0C0C, 32'h0000_00C1, 32'h0000_00C2, 1'b0, 1'b0, 1'b1, 7'd1, 6'd0);
    wait_idle("after_drop_idle");
    chk("overrun_sticky", 128'(overrun), 128'(1));

    // Clear requested during WR
    @(negedge clk);
    sample_valid = 1'b1; sample_level = 16'h0D0D; df_second = 32'h0000_00D5; df_minute = 32'h0000_00D6;
    push_exp(7'd1, 6'd0, 16'h0D0D, 32'h0000_00D5, 32'h0000_00D6);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (sec_we) found = 1'b1;
    end
    chk("clr_wr_seen", 128'(found), 128'(1));
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    mon_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (sec_we) found = 1'b1;
      else @(negedge clk);
    end
    chk("clr_start", 128'(found), 128'(1));
    for (int a = 0; a < 100; a++) begin
      mw = (a < 60);
      chk($sformatf("clr_addr%0d", a),
          128'({sec_we, min_we, sec_addr, (mw ? min_addr : 6'd0), sec_wdata, min_wdata, clear_done, busy}),
          128'({1'b1, mw, 7'(a), (mw ? 6'(a) : 6'd0), 64'd0, 1'b0, 1'b1}));
      @(negedge clk);
    end
    chk("clr_done", 128'({clear_done, overrun, sec_we, min_we, busy}), 128'(5'b10000));
    @(negedge clk);
    chk("clr_done_once", 128'({clear_done, busy}), 128'(0));
    mon_en = 1'b1;
    send(16'h0E0E, 32'h0000_00E1, 32'h0000_00E2, 1'b0, 1'b0, 1'b1, 7'd2, 6'd0);
    wait_idle("after_clr_idle");

    // Reset mid-WAIT with a clear pending
    mon_en = 1'b0;
    send(16'h0F0F, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 128'({df_level, sec_addr, min_addr, mem_rd_en, sec_we, min_we,
                                 sec_wdata, min_wdata, busy, overrun, clear_done}), 128'(0));
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sec_we || min_we || busy || mem_rd_en) found = 1'b1;
    end
    chk("rst_no_clear", 128'(found), 128'(0));
    mon_en = 1'b1;
    send(16'h1111, 32'h0000_1112, 32'h0000_1113, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    wait_idle("after_rst_idle");

    // Marks: min_mark overrides, sec_idx wraps at 59
    do_reset();
    repeat (58) pulse_marks(1'b1, 1'b0);
    send(16'h2001, 32'h0000_2001, 32'h0000_3001, 1'b0, 1'b0, 1'b1, 7'd0, 6'd58);
    wait_idle("mk58_idle");
    pulse_marks(1'b1, 1'b1);
    send(16'h2002, 32'h0000_2002, 32'h0000_3002, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    wait_idle("mk_both_idle");
    repeat (59) pulse_marks(1'b1, 1'b0);
    send(16'h2003, 32'h0000_2003, 32'h0000_3003, 1'b0, 1'b0, 1'b1, 7'd0, 6'd59);
    wait_idle("mk59_idle");
    pulse_marks(1'b1, 1'b1);
    send(16'h2004, 32'h0000_2004, 32'h0000_3004, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    wait_idle("mk59_both_idle");
    repeat (59) pulse_marks(1'b1, 1'b0);
    pulse_marks(1'b1, 1'b0);
    send(16'h2005, 32'h0000_2005, 32'h0000_3005, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    wait_idle("mk_wrap_idle");

    // Mark coincident with accept
    do_reset();
    send(16'h3001, 32'h0000_4001, 32'h0000_5001, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    wait_idle("co1_idle");
    send(16'h3002, 32'h0000_4002, 32'h0000_5002, 1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
    wait_idle("co2_idle");
    send(16'h3003, 32'h0000_4003, 32'h0000_5003, 1'b0, 1'b0, 1'b1, 7'd1, 6'd0);
    wait_idle("co3_idle");
    send(16'h3004, 32'h0000_4004, 32'h0000_5004, 1'b1, 1'b0, 1'b1, 7'd1, 6'd0);
    wait_idle("co_mark_idle");
    send(16'h3005, 32'h0000_4005, 32'h0000_5005, 1'b0, 1'b0, 1'b1, 7'd0, 6'd1);
    wait_idle("co_next_idle");

    @(negedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
